// File: rtl/rx_ber_errblk_ctrl_pkg.sv
// Shared PCS receive definitions: BER/snapshot
// state encodings and 66b sync-header constants.
package rx_ber_errblk_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TEST  = 2'd1,
    HIBER = 2'd2
  } ber_state_e;

  typedef enum logic [1:0] {
    SIDLE = 2'd0,
    SCAP  = 2'd1,
    SACK  = 2'd2
  } snap_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int TIMER_CYCLES_156M = 19531;

  localparam int TIMER_W = 20;
  localparam int WIN_W   = 8;
  localparam int CNT_W   = 6;
  localparam int TOT_W   = 16;

  function automatic logic sh_bad(
    input logic       valid,
    input logic [1:0] sh
  );
    return valid && (sh != SH_DATA) && (sh != SH_CTRL);
  endfunction

endpackage

// File: rtl/rx_ber_window_timer.sv
// BER window timer with window-end strobe and a
// saturating completed-window counter.
module rx_ber_window_timer
  import rx_ber_errblk_ctrl_pkg::*;
#(
  parameter int TIMER_CYCLES = TIMER_CYCLES_156M,
  parameter int SAT_WINDOWS  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             win_clr,
  output logic             win_end,
  output logic [WIN_W-1:0] win_cnt
);

  localparam logic [TIMER_W-1:0] T_LAST =
    TIMER_W'(TIMER_CYCLES - 1);
  localparam logic [WIN_W-1:0] W_SAT =
    WIN_W'(SAT_WINDOWS);

  logic [TIMER_W-1:0] timer;

  assign win_end = run && (timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      win_cnt <= '0;
    end else begin
      if (!run || win_end) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      // a window closing on the clear cycle still counts
      if (win_clr) begin
        win_cnt <= win_end ? WIN_W'(1) : '0;
      end else if (win_end && (win_cnt < W_SAT)) begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_ber_errblk_ctrl.sv
// Receive BER monitor driving hi_ber, plus the
// errored-block snapshot/clear sequencer.
module rx_ber_errblk_ctrl
  import rx_ber_errblk_ctrl_pkg::*;
#(
  parameter int TIMER_CYCLES = TIMER_CYCLES_156M,
  parameter int BER_THRESH   = 16,
  parameter int SNAP_WINDOWS = 8
) (
  input  logic             clk156,
  input  logic             rstb156,
  input  logic             blk_lock,
  input  logic             sh_valid,
  input  logic [1:0]       sh_in,
  input  logic [7:0]       errd_blks,
  input  logic             snap_req,
  output logic             hi_ber,
  output logic             clear_errblk,
  output logic             snap_ack,
  output logic [7:0]       errd_snap,
  output logic [CNT_W-1:0] ber_cnt,
  output logic [TOT_W-1:0] ber_total
);

  localparam logic [CNT_W-1:0] THR =
    CNT_W'(BER_THRESH);
  localparam logic [WIN_W-1:0] SNAP_N =
    WIN_W'(SNAP_WINDOWS);
  localparam int WIN_SAT =
    (SNAP_WINDOWS != 0) ? SNAP_WINDOWS : 255;
  localparam logic AUTO_EN = (SNAP_WINDOWS != 0);

  ber_state_e       ber_st;
  snap_state_e      snap_st;
  logic             bad;
  logic             run;
  logic             win_end;
  logic             auto_trig;
  logic             win_clr;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_new;

  assign bad       = sh_bad(sh_valid, sh_in);
  assign run       = blk_lock && (ber_st != INIT);
  assign auto_trig = AUTO_EN && (win_cnt == SNAP_N);
  assign win_clr   = (snap_st == SIDLE) && auto_trig;
  assign cnt_inc   = ber_cnt + 1'b1;
  assign cnt_new   = {{(CNT_W-1){1'b0}}, bad};

  rx_ber_window_timer #(
    .TIMER_CYCLES (TIMER_CYCLES),
    .SAT_WINDOWS  (WIN_SAT)
  ) u_timer (
    .clk     (clk156),
    .rst_n   (rstb156),
    .run     (run),
    .win_clr (win_clr),
    .win_end (win_end),
    .win_cnt (win_cnt)
  );

  // window end outranks the threshold; that header opens the new window
  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156) begin
      ber_st  <= INIT;
      hi_ber  <= 1'b0;
      ber_cnt <= '0;
    end else if (!blk_lock) begin
      ber_st  <= INIT;
      hi_ber  <= 1'b0;
      ber_cnt <= '0;
    end else begin
      unique case (ber_st)
        INIT: begin
          ber_st  <= TEST;
          hi_ber  <= 1'b0;
          ber_cnt <= '0;
        end
        TEST: begin
          if (win_end) begin
            hi_ber  <= 1'b0;
            ber_cnt <= cnt_new;
          end else if (bad && (cnt_inc >= THR)) begin
            ber_st  <= HIBER;
            hi_ber  <= 1'b1;
            ber_cnt <= THR;
          end else if (bad) begin
            ber_cnt <= cnt_inc;
          end
        end
        HIBER: begin
          if (win_end) begin
            ber_st  <= TEST;
            hi_ber  <= 1'b0;
            ber_cnt <= cnt_new;
          end
        end
        default: begin
          ber_st  <= INIT;
          hi_ber  <= 1'b0;
          ber_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156) begin
      ber_total <= '0;
    end else if (bad && (ber_total != '1)) begin
      ber_total <= ber_total + 1'b1;
    end
  end

  // capture and clear share one edge so no block is lost or doubled
  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156) begin
      snap_st      <= SIDLE;
      clear_errblk <= 1'b0;
      snap_ack     <= 1'b0;
      errd_snap    <= '0;
    end else begin
      unique case (snap_st)
        SIDLE: begin
          snap_ack <= 1'b0;
          if (snap_req || auto_trig) begin
            snap_st      <= SCAP;
            clear_errblk <= 1'b1;
          end
        end
        SCAP: begin
          snap_st      <= SACK;
          errd_snap    <= errd_blks;
          clear_errblk <= 1'b0;
          snap_ack     <= 1'b1;
        end
        SACK: begin
          snap_st  <= SIDLE;
          snap_ack <= 1'b0;
        end
        default: begin
          snap_st      <= SIDLE;
          clear_errblk <= 1'b0;
          snap_ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ber_errblk_ctrl.sv
// Two DUT configurations on one directed stimulus
// timeline, checked each cycle against a window model.
module tb_rx_ber_errblk_ctrl;

  logic       clk156;
  logic       rstb156;
  logic       blk_lock;
  logic       sh_valid;
  logic [1:0] sh_in;
  logic [7:0] errd_blks;
  logic       snap_req;

  logic [1:0] hi_ber;
  logic [1:0] clear_errblk;
  logic [1:0] snap_ack;
  logic [7:0] errd_snap [2];
  logic [5:0] ber_cnt [2];
  logic [15:0] ber_total [2];

  int checks = 0;
  int errors = 0;
  int ecnt = -1;

  int m_pos [2];
  int m_nbad [2];
  int m_total [2];
  int m_wins [2];
  int m_lt [2];
  bit m_run [2];
  bit m_hi [2];
  int m_snap [2];
  int clr_n [2];
  int ack_n [2];

  rx_ber_errblk_ctrl #(
    .TIMER_CYCLES (100),
    .BER_THRESH   (16),
    .SNAP_WINDOWS (0)
  ) dut_a (
    .clk156       (clk156),
    .rstb156      (rstb156),
    .blk_lock     (blk_lock),
    .sh_valid     (sh_valid),
    .sh_in        (sh_in),
    .errd_blks    (errd_blks),
    .snap_req     (snap_req),
    .hi_ber       (hi_ber[0]),
    .clear_errblk (clear_errblk[0]),
    .snap_ack     (snap_ack[0]),
    .errd_snap    (errd_snap[0]),
    .ber_cnt      (ber_cnt[0]),
    .ber_total    (ber_total[0])
  );

  rx_ber_errblk_ctrl #(
    .TIMER_CYCLES (50),
    .BER_THRESH   (16),
    .SNAP_WINDOWS (2)
  ) dut_b (
    .clk156       (clk156),
    .rstb156      (rstb156),
    .blk_lock     (blk_lock),
    .sh_valid     (sh_valid),
    .sh_in        (sh_in),
    .errd_blks    (errd_blks),
    .snap_req     (snap_req),
    .hi_ber       (hi_ber[1]),
    .clear_errblk (clear_errblk[1]),
    .snap_ack     (snap_ack[1]),
    .errd_snap    (errd_snap[1]),
    .ber_cnt      (ber_cnt[1]),
    .ber_total    (ber_total[1])
  );

  initial begin
    clk156 = 1'b0;
    forever #5 clk156 = ~clk156;
  end

  function automatic int tc_of(input int i);
    return (i == 0) ? 100 : 50;
  endfunction

  function automatic int sw_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  localparam int TH = 16;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d act=%0h exp=%0h",
               nm, ecnt, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0;
      m_nbad[i] = 0;
      m_total[i] = 0;
      m_wins[i] = 0;
      m_lt[i] = -100;
      m_run[i] = 0;
      m_hi[i] = 0;
      m_snap[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit bad;
    bit wend;
    bit idle;
    bit autot;
    int sat;
    bad = sh_valid && (sh_in == 2'b00 || sh_in == 2'b11);
    if (bad && m_total[i] < 65535) m_total[i]++;
    wend = m_run[i] && blk_lock && (m_pos[i] == tc_of(i) - 1);
    sat = (sw_of(i) != 0) ? sw_of(i) : 255;
    idle = (ecnt - m_lt[i]) >= 3;
    autot = (sw_of(i) != 0) && (m_wins[i] == sw_of(i));
    if (idle && (snap_req || autot)) m_lt[i] = ecnt;
    if (ecnt == m_lt[i] + 1) m_snap[i] = int'(errd_blks);
    if (idle && autot) m_wins[i] = wend ? 1 : 0;
    else if (wend && m_wins[i] < sat) m_wins[i]++;
    if (!blk_lock) begin
      m_run[i] = 0; m_pos[i] = 0;
      m_nbad[i] = 0; m_hi[i] = 0;
    end else if (!m_run[i]) begin
      m_run[i] = 1; m_pos[i] = 0;
      m_nbad[i] = 0; m_hi[i] = 0;
    end else if (wend) begin
      m_pos[i] = 0; m_hi[i] = 0;
      m_nbad[i] = bad ? 1 : 0;
    end else begin
      m_pos[i]++;
      if (bad) m_nbad[i]++;
      if (m_nbad[i] >= TH) m_hi[i] = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk156 or negedge rstb156);
      if (!rstb156) begin
        model_reset();
      end else begin
        ecnt++;
        model_step(0);
        model_step(1);
      end
    end
  end

  initial begin
    clr_n = '{0, 0};
    ack_n = '{0, 0};
    forever begin
      @(negedge clk156);
      for (int i = 0; i < 2; i++) begin
        int ec;
        ec = (m_nbad[i] > TH) ? TH : m_nbad[i];
        chk($sformatf("hi_ber[%0d]", i), hi_ber[i], m_hi[i]);
        chk($sformatf("ber_cnt[%0d]", i), ber_cnt[i], ec);
        chk($sformatf("ber_total[%0d]", i),
            ber_total[i], m_total[i]);
        chk($sformatf("clear[%0d]", i), clear_errblk[i],
            (rstb156 && ecnt == m_lt[i]) ? 1 : 0);
        chk($sformatf("ack[%0d]", i), snap_ack[i],
            (rstb156 && ecnt == m_lt[i] + 1) ? 1 : 0);
        chk($sformatf("snap[%0d]", i), errd_snap[i], m_snap[i]);
        if (clear_errblk[i]) clr_n[i]++;
        if (snap_ack[i]) ack_n[i]++;
      end
    end
  end

  task automatic drive(input int k);
    bit b;
    b = (k >= 10 && k <= 25) || (k >= 150 && k <= 164) ||
        (k == 200) || (k >= 310 && k <= 325) || (k == 332);
    if (b) begin
      sh_valid = 1'b1;
      sh_in = k[0] ? 2'b11 : 2'b00;
    end else if (k % 7 == 0) begin
      sh_valid = 1'b0;
      sh_in = 2'b00;
    end else begin
      sh_valid = 1'b1;
      sh_in = k[0] ? 2'b01 : 2'b10;
    end
    blk_lock = !(k >= 330 && k <= 334);
    snap_req = (k == 101 || k == 102 || k == 460);
    errd_blks = (k < 150) ? 8'h2A : 8'h33;
  endtask

  task automatic lit(input int e);
    case (e)
      0: begin
        chk("L0 hi", hi_ber[0], 0);
        chk("L0 cnt", ber_cnt[0], 0);
      end
      24: begin
        chk("L24 cnt", ber_cnt[0], 15);
        chk("L24 hi", hi_ber[0], 0);
      end
      25: begin
        chk("L25 hi", hi_ber[0], 1);
        chk("L25 cnt", ber_cnt[0], 16);
      end
      99: chk("L99 hi", hi_ber[0], 1);
      100: begin
        chk("L100 hi", hi_ber[0], 0);
        chk("L100 cnt", ber_cnt[0], 0);
        chk("L100 clr", clear_errblk[0], 0);
      end
      101: begin
        chk("L101 clr_a", clear_errblk[0], 1);
        chk("L101 clr_b", clear_errblk[1], 1);
        chk("L101 ack_a", snap_ack[0], 0);
        chk("L101 snap_a", errd_snap[0], 0);
      end
      102: begin
        chk("L102 ack_a", snap_ack[0], 1);
        chk("L102 snap_a", errd_snap[0], 8'h2A);
        chk("L102 clr_a", clear_errblk[0], 0);
        chk("L102 ack_b", snap_ack[1], 1);
        chk("L102 snap_b", errd_snap[1], 8'h2A);
      end
      103: chk("L103 ack_a", snap_ack[0], 0);
      151: chk("L151 clr_b", clear_errblk[1], 0);
      164: chk("L164 cnt", ber_cnt[0], 15);
      199: begin
        chk("L199 cnt", ber_cnt[0], 15);
        chk("L199 hi", hi_ber[0], 0);
      end
      200: begin
        chk("L200 cnt", ber_cnt[0], 1);
        chk("L200 hi", hi_ber[0], 0);
        chk("L200 tot", ber_total[0], 32);
        chk("L200 clr_b", clear_errblk[1], 0);
      end
      201: chk("L201 clr_b", clear_errblk[1], 1);
      202: begin
        chk("L202 ack_b", snap_ack[1], 1);
        chk("L202 snap_b", errd_snap[1], 8'h33);
      end
      329: begin
        chk("L329 hi", hi_ber[0], 1);
        chk("L329 tot", ber_total[0], 48);
      end
      330: begin
        chk("L330 hi", hi_ber[0], 0);
        chk("L330 cnt", ber_cnt[0], 0);
        chk("L330 tot", ber_total[0], 48);
      end
      332: begin
        chk("L332 tot", ber_total[0], 49);
        chk("L332 cnt", ber_cnt[0], 0);
      end
      460: chk("L460 clr_a", clear_errblk[0], 1);
      default: ;
    endcase
  endtask

  initial begin
    rstb156 = 1'b1;
    blk_lock = 1'b1;
    sh_valid = 1'b0;
    sh_in = 2'b00;
    errd_blks = 8'h2A;
    snap_req = 1'b0;
    #1 rstb156 = 1'b0;
    repeat (3) @(negedge clk156);
    chk("R hi", hi_ber[0], 0);
    chk("R cnt", ber_cnt[1], 0);
    chk("R tot", ber_total[0], 0);
    chk("R snap", errd_snap[1], 0);
    rstb156 = 1'b1;
    drive(0);
    for (int k = 1; k <= 480; k++) begin
      @(negedge clk156);
      lit(k - 1);
      if (k - 1 == 460) begin
        #2 rstb156 = 1'b0;
        #1;
        chk("RM clr_a", clear_errblk[0], 0);
        chk("RM tot_a", ber_total[0], 0);
        chk("RM hi_b", hi_ber[1], 0);
        chk("RM snap_b", errd_snap[1], 0);
        repeat (3) @(negedge clk156);
        #2 rstb156 = 1'b1;
      end
      drive(k);
    end
    @(negedge clk156);
    chk("clr pulses a", clr_n[0], 2);
    chk("ack pulses a", ack_n[0], 1);
    chk("clr pulses b", clr_n[1], 5);
    chk("ack pulses b", ack_n[1], 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
